filter_channel_scheduler: RTL and testbench

//  Time-multiplexes one SimpleFilter core among NUM_CH AXI-Stream input channels.
//  - Round-robin arbitration: at most one sample per cycle is issued to the filter.
//  - Each issued sample's channel ID goes into an in-order tag FIFO.
//  - Each filter result is routed back to the matching per-channel output stream.
//  - Sits between the channel sources and the filter; also sequences drain/idle.

---
 rtl/filter_channel_scheduler.sv | 172 +++++++++++++++++
 tb/tb_filter_channel_scheduler.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_channel_scheduler.sv
// Shares one filter core among NUM_CH AXI-Stream channels.
// The arbiter is round-robin and issues at most one sample per cycle.
// An in-order tag FIFO records which channel owns each sample inside the filter.
// Each filter result is steered back to that channel's output lane.
module filter_channel_scheduler #(
    parameter int NUM_CH       = 4,
    parameter int DATA_W       = 32,
    parameter int MAX_INFLIGHT = 16
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic [NUM_CH-1:0]          ch_enable,
    input  logic                       drain_req,
    output logic                       busy,
    output logic                       drain_done,
    output logic                       err_spurious,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    input  logic [NUM_CH-1:0]          s_axis_tvalid,
    output logic [NUM_CH-1:0]          s_axis_tready,
    input  logic [NUM_CH*DATA_W-1:0]   s_axis_tdata,
    output logic                       f_tvalid,
    output logic [DATA_W-1:0]          f_tdata,
    input  logic                       f_res_tvalid,
    input  logic [DATA_W-1:0]          f_res_tdata,
    output logic [NUM_CH-1:0]          m_axis_tvalid,
    output logic [NUM_CH*DATA_W-1:0]   m_axis_tdata
);

    localparam int TAG_W = $clog2(NUM_CH);
    localparam int AW    = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = AW + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN
    } state_t;

    state_t                 state_q, state_d;
    logic [TAG_W-1:0]       rr_q, rr_d;
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]       inflight_q, inflight_d;
    logic                   f_tvalid_q, f_tvalid_d;
    logic [DATA_W-1:0]      f_tdata_q, f_tdata_d;
    logic                   err_q, err_d;
    logic [NUM_CH-1:0]      m_tvalid_q, m_tvalid_d;
    logic [NUM_CH*DATA_W-1:0] m_tdata_q, m_tdata_d;

    logic [TAG_W-1:0]       tag_mem [MAX_INFLIGHT];

    logic [NUM_CH-1:0]      eligible;
    logic [NUM_CH-1:0]      grant;
    logic [TAG_W-1:0]       grant_idx;
    logic                   can_issue;
    logic                   hs;
    logic                   pop;
    logic [TAG_W-1:0]       pop_tag;
    int                     sel;

    // Next-state logic: IDLE -> RUN -> DRAIN -> IDLE, with the drain_done pulse on the exit from DRAIN
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can infer a latch.
        state_d    = state_q;
        drain_done = 1'b0;
        case (state_q)
            ST_IDLE:  if (|ch_enable && !drain_req) state_d = ST_RUN;
            ST_RUN:   if (drain_req || ch_enable == '0) state_d = ST_DRAIN;
            ST_DRAIN: begin
                if (inflight_q == '0 && !f_tvalid_q) begin
                    state_d    = ST_IDLE;
                    drain_done = 1'b1;
                end
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    // Round-robin grant: the first eligible channel at or after rr_q wins; the grant is withheld while stopping or full
    always_comb begin
        eligible  = ch_enable & s_axis_tvalid;
        can_issue = (state_q == ST_RUN) && !drain_req && (inflight_q < CNT_W'(MAX_INFLIGHT));
        grant     = '0;
        grant_idx = '0;
        hs        = 1'b0;
        sel       = 0;
        if (can_issue) begin
            for (int k = 0; k < NUM_CH; k++) begin
                sel = (int'(rr_q) + k) % NUM_CH;
                if (!hs && eligible[sel]) begin
                    hs        = 1'b1;
                    grant[sel] = 1'b1;
                    grant_idx = TAG_W'(sel);
                end
            end
        end
    end

    // Datapath next values: issue register, tag FIFO pointers, inflight count, and result routing
    always_comb begin
        pop     = f_res_tvalid && (inflight_q != '0);
        pop_tag = tag_mem[rd_ptr_q];

        rr_d       = hs ? TAG_W'((int'(grant_idx) + 1) % NUM_CH) : rr_q;
        wr_ptr_d   = hs  ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;

        inflight_d = inflight_q;
        case ({hs, pop})
            2'b10:   inflight_d = inflight_q + CNT_W'(1);
            2'b01:   inflight_d = inflight_q - CNT_W'(1);
            default: inflight_d = inflight_q;
        endcase

        f_tvalid_d = hs;
        f_tdata_d  = hs ? s_axis_tdata[grant_idx*DATA_W +: DATA_W] : f_tdata_q;

        // A result that arrives with no outstanding tag has no owner; it is flagged and dropped
        err_d = err_q | (f_res_tvalid && (inflight_q == '0));

        m_tvalid_d = '0;
        m_tdata_d  = m_tdata_q;
        if (pop) begin
            m_tvalid_d[pop_tag]                  = 1'b1;
            m_tdata_d[pop_tag*DATA_W +: DATA_W]  = f_res_tdata;
        end
    end

    // Tag storage: written on every handshake at the write pointer
    // NOTE: the storage array has no reset; the pointers and the count alone define which entries are valid.
    always_ff @(posedge aclk) begin
        if (hs) tag_mem[wr_ptr_q] <= grant_idx;
    end

    // State registers with asynchronous reset
    always_ff @(posedge aclk or negedge aresetn) begin
        // NOTE: non-blocking assignments let every flop sample the pre-edge values, whatever the statement order.
        if (!aresetn) begin
            state_q    <= ST_IDLE;
            rr_q       <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            f_tvalid_q <= 1'b0;
            f_tdata_q  <= '0;
            err_q      <= 1'b0;
            m_tvalid_q <= '0;
            m_tdata_q  <= '0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
            f_tvalid_q <= f_tvalid_d;
            f_tdata_q  <= f_tdata_d;
            err_q      <= err_d;
            m_tvalid_q <= m_tvalid_d;
            m_tdata_q  <= m_tdata_d;
        end
    end

    assign busy          = (state_q != ST_IDLE);
    assign err_spurious  = err_q;
    assign inflight      = inflight_q;
    assign s_axis_tready = grant;
    assign f_tvalid      = f_tvalid_q;
    assign f_tdata       = f_tdata_q;
    assign m_axis_tvalid = m_tvalid_q;
    assign m_axis_tdata  = m_tdata_q;

endmodule

// File: tb/tb_filter_channel_scheduler.sv
// Directed bench for filter_channel_scheduler: an arbitration vector table plus hand-written corner sequences.
module tb_filter_channel_scheduler;

    localparam int NUM_CH       = 4;
    localparam int DATA_W       = 32;
    localparam int MAX_INFLIGHT = 16;
    localparam int CNT_W        = $clog2(MAX_INFLIGHT) + 1;

    logic                     aclk = 1'b0;
    logic                     aresetn = 1'b0;
    logic [NUM_CH-1:0]        ch_enable = '0;
    logic                     drain_req = 1'b0;
    logic                     busy;
    logic                     drain_done;
    logic                     err_spurious;
    logic [CNT_W-1:0]         inflight;
    logic [NUM_CH-1:0]        s_axis_tvalid = '0;
    logic [NUM_CH-1:0]        s_axis_tready;
    logic [NUM_CH*DATA_W-1:0] s_axis_tdata = '0;
    logic                     f_tvalid;
    logic [DATA_W-1:0]        f_tdata;
    logic                     f_res_tvalid = 1'b0;
    logic [DATA_W-1:0]        f_res_tdata = '0;
    logic [NUM_CH-1:0]        m_axis_tvalid;
    logic [NUM_CH*DATA_W-1:0] m_axis_tdata;

    filter_channel_scheduler #(
        .NUM_CH       (NUM_CH),
        .DATA_W       (DATA_W),
        .MAX_INFLIGHT (MAX_INFLIGHT)
    ) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .ch_enable     (ch_enable),
        .drain_req     (drain_req),
        .busy          (busy),
        .drain_done    (drain_done),
        .err_spurious  (err_spurious),
        .inflight      (inflight),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .f_tvalid      (f_tvalid),
        .f_tdata       (f_tdata),
        .f_res_tvalid  (f_res_tvalid),
        .f_res_tdata   (f_res_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tdata  (m_axis_tdata)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [NUM_CH-1:0] en;
        logic [NUM_CH-1:0] valid;
        logic [NUM_CH-1:0] exp_ready;
    } arb_vec_t;

    arb_vec_t tbl [13];
    int       errors = 0;
    int       checks = 0;
    int       exp_tags [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock and settle just past the rising edge
    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [DATA_W-1:0] lane(input logic [NUM_CH*DATA_W-1:0] v, input int i);
        return v[i*DATA_W +: DATA_W];
    endfunction

    function automatic logic [DATA_W-1:0] src_word(input int r, input int i);
        logic [DATA_W-1:0] w;
        w = 32'hA000_0000 | DATA_W'(r << 8) | DATA_W'(i);
        return w;
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"},     64'(busy), 64'd0);
        check({tag, "_ddone"},    64'(drain_done), 64'd0);
        check({tag, "_err"},      64'(err_spurious), 64'd0);
        check({tag, "_inflight"}, 64'(inflight), 64'd0);
        check({tag, "_tready"},   64'(s_axis_tready), 64'd0);
        check({tag, "_ftvalid"},  64'(f_tvalid), 64'd0);
        check({tag, "_ftdata"},   64'(f_tdata), 64'd0);
        check({tag, "_mtvalid"},  64'(m_axis_tvalid), 64'd0);
        check({tag, "_mtdata"},   64'(m_axis_tdata[63:0]), 64'd0);
    endtask

    task automatic do_reset();
        aresetn       = 1'b0;
        ch_enable     = '0;
        drain_req     = 1'b0;
        s_axis_tvalid = '0;
        f_res_tvalid  = 1'b0;
        repeat (5) @(posedge aclk);
        #1;
        check_all_zero("reset");
        aresetn = 1'b1;
    endtask

    initial begin
        int exp_inf;
        int tag;
        logic [DATA_W-1:0] exp_fdata;
        logic [DATA_W-1:0] res;

        // Arbitration vectors, applied from rr=0 in RUN
        tbl[0]  = '{4'hF, 4'hF, 4'b0001};
        tbl[1]  = '{4'hF, 4'hF, 4'b0010};
        tbl[2]  = '{4'hF, 4'hF, 4'b0100};
        tbl[3]  = '{4'hF, 4'hF, 4'b1000};
        tbl[4]  = '{4'hF, 4'hF, 4'b0001};
        tbl[5]  = '{4'hF, 4'b0001, 4'b0001};
        tbl[6]  = '{4'hF, 4'b0000, 4'b0000};
        tbl[7]  = '{4'b1101, 4'hF, 4'b0100};
        tbl[8]  = '{4'b0101, 4'hF, 4'b0001};
        tbl[9]  = '{4'b0101, 4'b1010, 4'b0000};
        tbl[10] = '{4'hF, 4'b1001, 4'b1000};
        tbl[11] = '{4'b1000, 4'hF, 4'b1000};
        tbl[12] = '{4'hF, 4'b0110, 4'b0010};

        // Single sample on channel 0
        do_reset();
        ch_enable = 4'b0001;
        step();
        check("t1_busy", 64'(busy), 64'd1);
        s_axis_tvalid = 4'b0001;
        s_axis_tdata[31:0] = 32'h0000_FFFF;
        #1;
        check("t1_tready", 64'(s_axis_tready), 64'h1);
        step();
        s_axis_tvalid = '0;
        check("t1_ftvalid", 64'(f_tvalid), 64'd1);
        check("t1_ftdata", 64'(f_tdata), 64'hFFFF);
        check("t1_inflight", 64'(inflight), 64'd1);
        step();
        check("t1_ftvalid_low", 64'(f_tvalid), 64'd0);
        check("t1_ftdata_hold", 64'(f_tdata), 64'hFFFF);
        f_res_tvalid = 1'b1;
        f_res_tdata  = 32'h1234_5678;
        step();
        f_res_tvalid = 1'b0;
        check("t1_mtvalid", 64'(m_axis_tvalid), 64'h1);
        check("t1_lane0", 64'(lane(m_axis_tdata, 0)), 64'h1234_5678);
        check("t1_inflight0", 64'(inflight), 64'd0);
        step();
        check("t1_mtvalid_low", 64'(m_axis_tvalid), 64'h0);
        check("t1_lane0_hold", 64'(lane(m_axis_tdata, 0)), 64'h1234_5678);

        // Round-robin table
        do_reset();
        ch_enable = 4'hF;
        step();
        exp_inf   = 0;
        exp_fdata = '0;
        for (int r = 0; r < 13; r++) begin
            ch_enable     = tbl[r].en;
            s_axis_tvalid = tbl[r].valid;
            for (int i = 0; i < NUM_CH; i++) s_axis_tdata[i*DATA_W +: DATA_W] = src_word(r, i);
            #1;
            check($sformatf("t2_tready_r%0d", r), 64'(s_axis_tready), 64'(tbl[r].exp_ready));
            step();
            if (tbl[r].exp_ready != '0) begin
                exp_inf++;
                tag = 0;
                for (int i = 0; i < NUM_CH; i++) if (tbl[r].exp_ready[i]) tag = i;
                exp_tags.push_back(tag);
                exp_fdata = src_word(r, tag);
            end
            check($sformatf("t2_ftvalid_r%0d", r), 64'(f_tvalid), 64'(tbl[r].exp_ready != '0));
            check($sformatf("t2_ftdata_r%0d", r), 64'(f_tdata), 64'(exp_fdata));
            check($sformatf("t2_inflight_r%0d", r), 64'(inflight), 64'(exp_inf));
        end
        s_axis_tvalid = '0;
        for (int k = 0; exp_tags.size() > 0; k++) begin
            tag = exp_tags.pop_front();
            res = 32'hB000_0000 + DATA_W'(k);
            f_res_tvalid = 1'b1;
            f_res_tdata  = res;
            step();
            exp_inf--;
            check($sformatf("t2_mtvalid_k%0d", k), 64'(m_axis_tvalid), 64'(1 << tag));
            check($sformatf("t2_lane_k%0d", k), 64'(lane(m_axis_tdata, tag)), 64'(res));
            check($sformatf("t2_inflight_k%0d", k), 64'(inflight), 64'(exp_inf));
        end
        f_res_tvalid = 1'b0;
        step();
        check("t2_mtvalid_end", 64'(m_axis_tvalid), 64'h0);

        // Filter stalled: capacity limit and resume
        ch_enable     = 4'b0001;
        s_axis_tvalid = 4'b0001;
        for (int c = 0; c < 20; c++) begin
            s_axis_tdata[31:0] = 32'hC000_0000 + DATA_W'(c);
            #1;
            check($sformatf("t3_tready_c%0d", c), 64'(s_axis_tready), (c < 16) ? 64'h1 : 64'h0);
            step();
            check($sformatf("t3_inflight_c%0d", c), 64'(inflight), (c < 16) ? 64'(c + 1) : 64'd16);
        end
        s_axis_tdata[31:0] = 32'hC000_0100;
        f_res_tvalid = 1'b1;
        f_res_tdata  = 32'hD000_0000;
        #1;
        check("t3_tready_full", 64'(s_axis_tready), 64'h0);
        step();
        f_res_tvalid = 1'b0;
        check("t3_inflight_15", 64'(inflight), 64'd15);
        check("t3_mtvalid", 64'(m_axis_tvalid), 64'h1);
        check("t3_lane0", 64'(lane(m_axis_tdata, 0)), 64'hD000_0000);
        #1;
        check("t3_tready_resume", 64'(s_axis_tready), 64'h1);
        step();
        s_axis_tvalid = '0;
        check("t3_inflight_16", 64'(inflight), 64'd16);
        check("t3_ftdata_17th", 64'(f_tdata), 64'hC000_0100);
        f_res_tvalid = 1'b1;
        repeat (16) step();
        f_res_tvalid = 1'b0;
        check("t3_inflight_empty", 64'(inflight), 64'd0);

        // Drain with three samples in flight
        s_axis_tvalid = 4'b0001;
        repeat (3) step();
        check("t4_inflight3", 64'(inflight), 64'd3);
        drain_req     = 1'b1;
        s_axis_tvalid = '0;
        step();
        s_axis_tvalid = 4'b0001;
        #1;
        check("t4_tready", 64'(s_axis_tready), 64'h0);
        check("t4_busy", 64'(busy), 64'd1);
        check("t4_ddone_early", 64'(drain_done), 64'd0);
        for (int k = 0; k < 3; k++) begin
            f_res_tvalid = 1'b1;
            f_res_tdata  = 32'hE000_0000 + DATA_W'(k);
            step();
            check($sformatf("t4_ddone_k%0d", k), 64'(drain_done), (k == 2) ? 64'd1 : 64'd0);
            check($sformatf("t4_mtvalid_k%0d", k), 64'(m_axis_tvalid), 64'h1);
            check($sformatf("t4_inflight_k%0d", k), 64'(inflight), 64'(2 - k));
            check($sformatf("t4_busy_k%0d", k), 64'(busy), 64'd1);
        end
        f_res_tvalid = 1'b0;
        step();
        check("t4_busy_idle", 64'(busy), 64'd0);
        check("t4_ddone_once", 64'(drain_done), 64'd0);
        check("t4_inflight_idle", 64'(inflight), 64'd0);
        drain_req     = 1'b0;
        s_axis_tvalid = '0;
        ch_enable     = '0;

        // Spurious result with an empty tag FIFO
        check("t5_err_before", 64'(err_spurious), 64'd0);
        f_res_tvalid = 1'b1;
        f_res_tdata  = 32'h5555_5555;
        step();
        f_res_tvalid = 1'b0;
        check("t5_err", 64'(err_spurious), 64'd1);
        check("t5_mtvalid", 64'(m_axis_tvalid), 64'h0);
        check("t5_inflight", 64'(inflight), 64'd0);
        step();
        check("t5_err_sticky", 64'(err_spurious), 64'd1);
        check("t5_inflight_hold", 64'(inflight), 64'd0);

        // Asynchronous reset with five samples in flight
        do_reset();
        ch_enable = 4'b0001;
        step();
        s_axis_tvalid = 4'b0001;
        s_axis_tdata[31:0] = 32'h7777_7777;
        repeat (5) step();
        check("t6_inflight5", 64'(inflight), 64'd5);
        #2;
        aresetn = 1'b0;
        #1;
        check_all_zero("t6_async");
        ch_enable     = '0;
        s_axis_tvalid = '0;
        @(posedge aclk);
        #1;
        aresetn      = 1'b1;
        f_res_tvalid = 1'b1;
        f_res_tdata  = 32'h6666_6666;
        step();
        f_res_tvalid = 1'b0;
        check("t6_err", 64'(err_spurious), 64'd1);
        check("t6_mtvalid", 64'(m_axis_tvalid), 64'h0);
        check("t6_inflight", 64'(inflight), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
